// File: rtl/axi_lite_ram_responder.sv
// axi_lite_ram_responder: AXI4-Lite slave backed by on-chip byte-strobed word RAM
// Read and write channels run independent FSMs; all responses are OKAY.
module axi_lite_ram_responder #(
    parameter int MEM_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [MEM_WIDTH-1:0] axi_araddr,
    input  logic                 axi_arvalid,
    output logic                 axi_arready,
    input  logic [2:0]           axi_arprot,
    output logic [31:0]          axi_rdata,
    output logic [1:0]           axi_rresp,
    output logic                 axi_rvalid,
    input  logic                 axi_rready,
    input  logic [MEM_WIDTH-1:0] axi_awaddr,
    input  logic                 axi_awvalid,
    output logic                 axi_awready,
    input  logic [2:0]           axi_awprot,
    input  logic [31:0]          axi_wdata,
    input  logic [3:0]           axi_wstrb,
    input  logic                 axi_wvalid,
    output logic                 axi_wready,
    output logic [1:0]           axi_bresp,
    output logic                 axi_bvalid,
    input  logic                 axi_bready,
    output logic [2:0]           reading_state,
    output logic [2:0]           writing_state
);
    typedef enum logic [2:0] {R_IDLE = 3'd0, R_FETCH = 3'd1, R_RESP = 3'd2} r_state_t;
    typedef enum logic [2:0] {
        W_IDLE = 3'd0, W_COMMIT = 3'd1, W_RESP = 3'd2, W_HAVE_ADDR = 3'd3, W_HAVE_DATA = 3'd4
    } w_state_t;
    localparam int WORDS = 2 ** (MEM_WIDTH - 2);
    logic [31:0] mem [WORDS];
    logic [MEM_WIDTH-3:0] raddr, waddr;
    logic [31:0] wdata_q, ram_rd;
    logic [3:0] wstrb_q;
    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    logic ar_hs, aw_hs, w_hs, unused;
    assign ar_hs = axi_arvalid && axi_arready;
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs = axi_wvalid && axi_wready;
    assign axi_rresp = 2'b00;
    assign axi_bresp = 2'b00;
    assign reading_state = r_state;
    assign writing_state = w_state;
    assign unused = ^{axi_arprot, axi_awprot, axi_araddr[1:0], axi_awaddr[1:0]};
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  r_next = ar_hs ? R_FETCH : R_IDLE;
            R_FETCH: r_next = R_RESP;
            R_RESP:  r_next = (axi_rvalid && axi_rready) ? R_IDLE : R_RESP;
            default: r_next = R_IDLE;
        endcase
    end
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:      w_next = (aw_hs && w_hs) ? W_COMMIT : aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : W_IDLE;
            W_HAVE_ADDR: w_next = w_hs ? W_COMMIT : W_HAVE_ADDR;
            W_HAVE_DATA: w_next = aw_hs ? W_COMMIT : W_HAVE_DATA;
            W_COMMIT:    w_next = W_RESP;
            W_RESP:      w_next = (axi_bvalid && axi_bready) ? W_IDLE : W_RESP;
            default:     w_next = W_IDLE;
        endcase
    end
    // rdata is loaded from the RAM output register one cycle into R_RESP, rvalid with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            raddr       <= '0;
        end else begin
            r_state     <= r_next;
            axi_arready <= r_next == R_IDLE;
            axi_rvalid  <= r_state == R_RESP && r_next == R_RESP;
            if (ar_hs) raddr <= axi_araddr[MEM_WIDTH-1:2];
            if (r_state == R_RESP && !axi_rvalid) axi_rdata <= ram_rd;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state     <= W_IDLE;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            waddr       <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            w_state     <= w_next;
            axi_awready <= w_next == W_IDLE || w_next == W_HAVE_DATA;
            axi_wready  <= w_next == W_IDLE || w_next == W_HAVE_ADDR;
            axi_bvalid  <= w_next == W_RESP;
            if (aw_hs) waddr <= axi_awaddr[MEM_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
        end
    end
    // Non-blocking read and write on the same edge gives read-first on collisions
    always_ff @(posedge clk) begin
        if (r_state == R_FETCH) ram_rd <= mem[raddr];
        if (w_state == W_COMMIT)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) mem[waddr][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_lite_ram_responder.sv
// tb_axi_lite_ram_responder: scoreboard bench for the AXI4-Lite RAM responder
module tb_axi_lite_ram_responder;
    logic clk = 0;
    logic rstn = 0;
    logic [20:0] araddr = '0, awaddr = '0;
    logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
    logic [2:0] arprot = '0, awprot = '0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0] rresp, bresp;
    logic [2:0] reading_state, writing_state;
    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    axi_lite_ram_responder #(.MEM_WIDTH(21)) dut (
        .clk(clk), .rstn(rstn),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready), .axi_arprot(arprot),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready), .axi_awprot(awprot),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .reading_state(reading_state), .writing_state(writing_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic do_read(input logic [20:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n = 0;
        araddr = a; arvalid = 1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1; arvalid = 0;
        lat = 0;
        while (!rvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        d = rdata; resp = rresp; rready = 1;
        @(posedge clk); #1; rready = 0;
    endtask

    task automatic do_write(input logic [20:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(awready && wready) && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        lat = 0;
        while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        resp = bresp; bready = 1;
        @(posedge clk); #1; bready = 0;
        model[int'(a[20:2])] = merge(model.exists(int'(a[20:2])) ? model[int'(a[20:2])] : 32'h0, d, s);
    endtask

    task automatic test_reset();
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || reading_state !== 3'd0 || writing_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/valid=%b rs=%0d ws=%0d, required all 0", {arready, awready, wready, rvalid, bvalid}, reading_state, writing_state);
        end
        #2 rstn = 1;
        @(posedge clk); #1;
        checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_readies: %b, required 111", {arready, awready, wready});
        end
    endtask

    task automatic test_basic();
        logic [31:0] got, exp;
        logic [1:0] resp;
        int lat;
        do_write(21'h10, 32'hDEADBEEF, 4'hF, resp, lat);
        checks++;
        if (lat !== 1 || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_write_resp: lat=%0d bresp=%b, required lat=1 bresp=00", lat, resp);
        end
        exp_q.push_back(model[int'(21'h10 >> 2)]);
        do_read(21'h10, got, resp, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || lat !== 2 || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read: data=%h lat=%0d rresp=%b, required data=%h lat=2 rresp=00", got, lat, resp, exp);
        end
    endtask

    task automatic test_split(input bit w_first, input logic [20:0] a, input logic [31:0] d);
        logic [31:0] got, exp;
        logic [1:0] resp;
        int lat;
        logic lead_rdy, other_rdy;
        awaddr = a; wdata = d; wstrb = 4'hF;
        if (w_first) wvalid = 1; else awvalid = 1;
        @(posedge clk); #1; wvalid = 0; awvalid = 0;
        lead_rdy = w_first ? wready : awready;
        other_rdy = w_first ? awready : wready;
        checks++;
        if (lead_rdy !== 1'b0 || other_rdy !== 1'b1 || writing_state !== (w_first ? 3'd4 : 3'd3)) begin
            errors++;
            $display("FAIL split_first_hs(w_first=%0d): lead_rdy=%b other_rdy=%b ws=%0d, required 0 1 %0d",
                     w_first, lead_rdy, other_rdy, writing_state, w_first ? 4 : 3);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (bvalid !== 1'b0) begin
                errors++;
                $display("FAIL split_early_bvalid(w_first=%0d): bvalid=%b, required 0", w_first, bvalid);
            end
        end
        if (w_first) awvalid = 1; else wvalid = 1;
        @(posedge clk); #1; wvalid = 0; awvalid = 0;
        lat = 0;
        while (!bvalid && lat < 50) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL split_bvalid_lat(w_first=%0d): lat=%0d, required 1", w_first, lat);
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        model[int'(a[20:2])] = d;
        exp_q.push_back(model[int'(a[20:2])]);
        do_read(a, got, resp, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL split_readback(w_first=%0d): data=%h, required %h", w_first, got, exp);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] got, exp;
        logic [1:0] resp;
        int lat;
        logic [3:0] strbs [3] = '{4'b0001, 4'b0000, 4'b1010};
        logic [31:0] datas [3] = '{32'h00000011, 32'hFFFFFFFF, 32'h5A00A500};
        do_write(21'h30, 32'hAABBCCDD, 4'hF, resp, lat);
        for (int k = 0; k < 3; k++) begin
            do_write(21'h30, datas[k], strbs[k], resp, lat);
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL strobe_bvalid(strb=%b): lat=%0d, required 1", strbs[k], lat);
            end
            exp_q.push_back(model[int'(21'h30 >> 2)]);
            do_read(21'h30, got, resp, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL strobe_readback(strb=%b): data=%h, required %h", strbs[k], got, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int n = 0;
        exp_q.push_back(model[int'(21'h10 >> 2)]);
        araddr = 21'h10; arvalid = 1;
        @(posedge clk); #1; arvalid = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        exp = exp_q.pop_front();
        repeat (5) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp || arready !== 1'b0) begin
                errors++;
                $display("FAIL read_stall: rvalid=%b rdata=%h arready=%b, required 1 %h 0", rvalid, rdata, arready, exp);
            end
            @(posedge clk); #1;
        end
        rready = 1; @(posedge clk); #1; rready = 0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL read_stall_release: rvalid=%b arready=%b, required 0 1", rvalid, arready);
        end
        awaddr = 21'h60; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        model[int'(21'h60 >> 2)] = 32'h01020304;
        repeat (5) begin
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL write_stall: bvalid=%b awready=%b wready=%b, required 1 0 0", bvalid, awready, wready);
            end
            @(posedge clk); #1;
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL write_stall_release: bvalid=%b awready=%b wready=%b, required 0 1 1", bvalid, awready, wready);
        end
    endtask

    task automatic test_collision();
        logic [31:0] got, exp;
        logic [1:0] resp;
        int lat, n = 0;
        do_write(21'h40, 32'h1, 4'hF, resp, lat);
        exp_q.push_back(model[int'(21'h40 >> 2)]);
        araddr = 21'h40; awaddr = 21'h40; wdata = 32'h2; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        @(posedge clk); #1; arvalid = 0; awvalid = 0; wvalid = 0;
        model[int'(21'h40 >> 2)] = 32'h2;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        got = rdata;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL collision_bvalid: bvalid=%b, required 1", bvalid);
        end
        rready = 1; bready = 1; @(posedge clk); #1; rready = 0; bready = 0;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL collision_read_first: data=%h, required %h", got, exp);
        end
        exp_q.push_back(model[int'(21'h43 >> 2)]);
        do_read(21'h43, got, resp, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL collision_new_unaligned: data=%h, required %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        logic [1:0] resp;
        int lat, n = 0;
        do_write(21'h50, 32'hCAFEF00D, 4'hF, resp, lat);
        awaddr = 21'h50; awvalid = 1;
        @(posedge clk); #1; awvalid = 0;
        araddr = 21'h10; arvalid = 1; wdata = 32'h0BADBAD0; wstrb = 4'hF;
        @(posedge clk); #1; arvalid = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (writing_state !== 3'd3 || reading_state !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_states: ws=%0d rs=%0d, required 3 2", writing_state, reading_state);
        end
        rstn = 0; #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0 || reading_state !== 3'd0 || writing_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy/valid=%b rs=%0d ws=%0d, required all 0", {arready, awready, wready, rvalid, bvalid}, reading_state, writing_state);
        end
        #2 rstn = 1;
        @(posedge clk); #1;
        checks++;
        if ({arready, awready, wready} !== 3'b111) begin
            errors++;
            $display("FAIL mid_reset_release: readies=%b, required 111", {arready, awready, wready});
        end
        exp_q.push_back(model[int'(21'h50 >> 2)]);
        do_read(21'h50, got, resp, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL mid_reset_write_discarded: data=%h, required %h", got, exp);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_basic();
        test_split(1'b1, 21'h20, 32'h11223344);
        test_split(1'b0, 21'h24, 32'h55667788);
        test_strobes();
        test_stall();
        test_collision();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
